pc_redirect_unit: RTL
=====================

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter: FLUSH_CYCLES, default 1, legal range 1..3; cycles FlushIF/FlushID stay high after a redirect.
REQ-003 Clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Rst  in  1  asynchronous, active-low reset.
REQ-005 Stall  in  1  hazard hold request; freeze PC.
REQ-006 PCSrc  in  1  redirect request from branch resolution.
REQ-007 PCNew  in  32  redirect target, valid when PCSrc=1.
REQ-008 PC  out  32  current fetch address, registered.
REQ-009 PCPlus4  out  32  PC+4, combinational from PC, modulo 2^32.
REQ-010 FlushIF  out  1  squash IF/ID contents, registered.
REQ-011 FlushID  out  1  squash ID/EX contents, registered.
REQ-012 Misaligned  out  1  one-cycle flag: last accepted PCNew had bits[1:0]!=0.
REQ-013 RedirectCount  out  16  count of accepted redirects.
REQ-014 State  out  2  encoded state: RUN=2'b00, HOLD=2'b01, FLUSH=2'b10.

Function
REQ-015 State machine SHALL have exactly three states: RUN, HOLD, FLUSH; 2'b11 is unreachable and SHALL recover to RUN on the next edge.
REQ-016 Redirect acceptance SHALL occur on an edge in RUN or HOLD with PCSrc=1; PC SHALL load {PCNew[31:2],2'b00} on that edge.
REQ-017 On acceptance, the next state SHALL be FLUSH, and an internal flush counter SHALL load FLUSH_CYCLES-1.
REQ-018 PCSrc SHALL take priority over Stall when both are high in RUN or HOLD.
REQ-019 In RUN/HOLD with PCSrc=0 and Stall=1: PC SHALL hold; next state HOLD.
REQ-020 In RUN/HOLD with PCSrc=0 and Stall=0: PC SHALL load PCPlus4; next state RUN.
REQ-021 FlushIF and FlushID SHALL both be 1 in every cycle State=FLUSH, and 0 otherwise.
REQ-022 In FLUSH: PC SHALL advance by 4 each edge regardless of Stall.
REQ-023 In FLUSH: PCSrc SHALL be ignored, with no PC load and no count increment.
REQ-024 In FLUSH: the counter SHALL decrement when nonzero; at zero the next state SHALL be RUN if Stall=0, else HOLD.
REQ-025 Redirect latency: the target SHALL appear on PC one cycle after the PCSrc sample edge; flush SHALL begin the same cycle.
REQ-026 PC increment SHALL wrap: 32'hFFFFFFFC+4 = 32'h00000000, with no flag.
REQ-027 Misaligned SHALL be 1 for exactly the cycle after an accepted redirect with PCNew[1:0]!=0, else 0.
REQ-028 RedirectCount SHALL increment by 1 per accepted redirect and saturate at 16'hFFFF.
REQ-029 A redirect target equal to the current PC SHALL still count, flush, and load.

Reset
REQ-030 On Rst=0, immediately and independent of Clk: PC=RESET_PC, State=RUN, FlushIF=0, FlushID=0, Misaligned=0, RedirectCount=0, flush counter=0.
REQ-031 Rst asserted mid-FLUSH SHALL abort the flush; no pending redirect or flush SHALL survive reset.
REQ-032 First PC advance SHALL occur on the first rising edge after Rst deasserts, with Stall=0 and PCSrc=0.

Verification
REQ-033 Reset then 3 free-running edges -> PC 0x0,0x4,0x8,0xC; flushes 0; State RUN.
REQ-034 PC=0x10, PCSrc=1 PCNew=0x100 with Stall=1 -> next PC=0x100, FlushIF=FlushID=1 for one cycle, RedirectCount=1, then PC=0x104.
REQ-035 FLUSH_CYCLES=3, redirect to 0x200, PCSrc=1 PCNew=0x400 on the next cycle -> PC 0x200,0x204,0x208 with flush high 3 cycles, second request ignored, count=1.
REQ-036 Redirect PCNew=0x00000103 -> PC=0x100, Misaligned=1 one cycle.
REQ-037 RESET_PC=0xFFFFFFF8, two free edges -> PC 0xFFFFFFFC then 0x00000000.
REQ-038 Rst pulsed low mid-FLUSH and for 65540 redirects -> async return to reset values; counter holds 0xFFFF at saturation.

Source files
------------

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_unit
// Purpose  : Fetch program-counter sequencer. It advances the PC by 4, holds
//            it on a hazard stall, and loads a word-aligned redirect target
//            from branch resolution. After each redirect it raises the
//            IF/ID and ID/EX squash strobes for FLUSH_CYCLES cycles.
// Ports    : Clk           - single clock, rising edge
//            Rst           - asynchronous reset, active low
//            Stall         - hazard hold request (freezes PC in RUN/HOLD)
//            PCSrc         - redirect request
//            PCNew[31:0]   - redirect target, meaningful when PCSrc=1
//            PC[31:0]      - registered fetch address
//            PCPlus4[31:0] - PC+4, combinational, wraps modulo 2^32
//            FlushIF       - registered squash of IF/ID
//            FlushID       - registered squash of ID/EX
//            Misaligned    - one-cycle flag, accepted target had bits[1:0]!=0
//            RedirectCount - saturating count of accepted redirects
//            State[1:0]    - RUN=00, HOLD=01, FLUSH=10
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1              // legal range 1..3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCNew,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FlushIF,
  output logic        FlushID,
  output logic        Misaligned,
  output logic [15:0] RedirectCount,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HOLD  = 2'b01,
    FLUSH = 2'b10
  } state_t;

  // The flush counter holds the number of FLUSH cycles still to come after
  // the current one, so the acceptance edge loads FLUSH_CYCLES-1.
  localparam logic [1:0]  FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

  state_t      state_q;
  logic [1:0]  flush_cnt_q;
  logic [31:0] pc_q;
  logic        flush_q;
  logic        misaligned_q;
  logic [15:0] redirect_cnt_q;
  logic [31:0] pc_plus4;

  // Natural 32-bit addition wraps 0xFFFFFFFC -> 0x00000000.
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q        <= RUN;
      flush_cnt_q    <= 2'd0;
      pc_q           <= RESET_PC;
      flush_q        <= 1'b0;
      misaligned_q   <= 1'b0;
      redirect_cnt_q <= 16'd0;
    end else begin
      // Misaligned is a single-cycle pulse; only the acceptance edge sets it.
      misaligned_q <= 1'b0;
      case (state_q)
        RUN, HOLD: begin
          if (PCSrc) begin
            // Redirect wins over a simultaneous stall.
            pc_q         <= {PCNew[31:2], 2'b00};
            state_q      <= FLUSH;
            flush_cnt_q  <= FLUSH_LOAD;
            flush_q      <= 1'b1;
            misaligned_q <= |PCNew[1:0];
            if (redirect_cnt_q != COUNT_MAX) begin
              redirect_cnt_q <= redirect_cnt_q + 16'd1;
            end
          end else if (Stall) begin
            state_q <= HOLD;
            flush_q <= 1'b0;
          end else begin
            pc_q    <= pc_plus4;
            state_q <= RUN;
            flush_q <= 1'b0;
          end
        end
        FLUSH: begin
          // The squashed slots are refilled sequentially; stall and any
          // further redirect request are ignored until the flush drains.
          pc_q <= pc_plus4;
          if (flush_cnt_q != 2'd0) begin
            flush_cnt_q <= flush_cnt_q - 2'd1;
            flush_q     <= 1'b1;
          end else begin
            state_q <= Stall ? HOLD : RUN;
            flush_q <= 1'b0;
          end
        end
        default: begin
          // Encoding 2'b11 cannot be reached; fall back to RUN if it appears.
          state_q     <= RUN;
          flush_cnt_q <= 2'd0;
          flush_q     <= 1'b0;
        end
      endcase
    end
  end

  assign PC            = pc_q;
  assign PCPlus4       = pc_plus4;
  assign FlushIF       = flush_q;
  assign FlushID       = flush_q;
  assign Misaligned    = misaligned_q;
  assign RedirectCount = redirect_cnt_q;
  assign State         = state_q;

endmodule
`default_nettype wire
